// File: rtl/pll_clk_supervisor_if.sv
// Bundles the PLL-facing and downstream-facing signals of the PLL clock
// supervisor. The supervisor uses the slave view; whoever drives the PLL lock
// and divisor settings uses the master view.
interface pll_clk_supervisor_if #(
    parameter int NUM_CH = 3,
    parameter int DIV_W  = 16
);
    logic                    pll_lock;
    logic [NUM_CH*DIV_W-1:0] div;
    logic                    pll_reset;
    logic                    locked;
    logic                    rst_out;
    logic [NUM_CH-1:0]       ce;
    logic [7:0]              retry_cnt;
    logic                    fault;

    modport slave (
        input  pll_lock, div,
        output pll_reset, locked, rst_out, ce, retry_cnt, fault
    );

    modport master (
        output pll_lock, div,
        input  pll_reset, locked, rst_out, ce, retry_cnt, fault
    );
endinterface

// File: rtl/pll_clk_supervisor.sv
// PLL supervisor and clock-enable generator. Pulses the PLL reset, qualifies
// the synchronised lock with a stability filter, retries on timeout or lock
// loss, and once qualified runs NUM_CH phase-aligned divide-by-N strobes.
module pll_clk_supervisor #(
    parameter int NUM_CH        = 3,
    parameter int DIV_W         = 16,
    parameter int FILT_CYC      = 1024,
    parameter int TIMEOUT_CYC   = 2700000,
    parameter int RST_PULSE_CYC = 27,
    parameter int MAX_RETRY     = 0
) (
    input  logic                    clkin,
    input  logic                    reset,
    pll_clk_supervisor_if.slave     bus
);

    localparam int FILT_W = $clog2(FILT_CYC + 1);
    localparam int TMR_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int PLS_W  = $clog2(RST_PULSE_CYC + 1);

    localparam logic [FILT_W-1:0] FILT_FULL     = FILT_W'(FILT_CYC);
    localparam logic [TMR_W-1:0]  TMR_LAST      = TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [PLS_W-1:0]  PLS_LAST      = PLS_W'(RST_PULSE_CYC - 1);
    localparam logic [31:0]       MAX_RETRY_U   = MAX_RETRY;
    localparam bit                RETRY_LIMITED = (MAX_RETRY != 0);

    typedef enum logic [1:0] {
        S_PLLRST,
        S_WAIT,
        S_RUN,
        S_FAULT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               lock_meta;
    logic               lock_s;
    logic [PLS_W-1:0]   pls_cnt;
    logic [TMR_W-1:0]   timer;
    logic [FILT_W-1:0]  filt;
    logic [7:0]         retry_q;
    logic [7:0]         retry_next;
    logic               pll_reset_q;
    logic               pll_reset_next;
    logic               locked_q;
    logic               locked_next;
    logic               fault_q;
    logic               fault_next;

    logic               first_q;
    logic               first_run;
    logic [DIV_W-1:0]   cnt   [NUM_CH];
    logic [DIV_W-1:0]   d_q   [NUM_CH];
    logic [DIV_W-1:0]   div_n [NUM_CH];
    logic [DIV_W-1:0]   d_eff [NUM_CH];
    logic [NUM_CH-1:0]  wrap;
    logic [NUM_CH-1:0]  ce_w;

    // Two-flop synchroniser bringing the asynchronous PLL lock into clkin.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            lock_meta <= 1'b0;
            lock_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking so lock_s takes the previous lock_meta, giving a true two-stage chain.
            lock_meta <= bus.pll_lock;
            lock_s    <= lock_meta;
        end
    end

    // State register plus the registered status outputs derived from the next state.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            state       <= S_PLLRST;
            retry_q     <= 8'd0;
            pll_reset_q <= 1'b1;
            locked_q    <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state       <= state_next;
            retry_q     <= retry_next;
            pll_reset_q <= pll_reset_next;
            locked_q    <= locked_next;
            fault_q     <= fault_next;
        end
    end

    // Next-state logic: reset pulse, lock qualification with timeout, lock-loss retry.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves a latch behind.
        state_next = state;
        retry_next = retry_q;
        unique case (state)
            S_PLLRST: begin
                if (pls_cnt == PLS_LAST) state_next = S_WAIT;
            end
            S_WAIT: begin
                // A completed filter beats a timeout expiring in the same cycle.
                if (filt == FILT_FULL) begin
                    state_next = S_RUN;
                    retry_next = 8'd0;
                end else if (timer == TMR_LAST) begin
                    retry_next = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
                    if (RETRY_LIMITED && (32'(retry_next) == MAX_RETRY_U)) begin
                        state_next = S_FAULT;
                    end else begin
                        state_next = S_PLLRST;
                    end
                end
            end
            S_RUN: begin
                // Lock loss is not a timeout, so retry_cnt is left alone.
                if (!lock_s) state_next = S_PLLRST;
            end
            S_FAULT: begin
                state_next = S_FAULT;
            end
            default: begin
                state_next = S_PLLRST;
            end
        endcase
        pll_reset_next = (state_next == S_PLLRST) || (state_next == S_FAULT);
        locked_next    = (state_next == S_RUN);
        fault_next     = (state_next == S_FAULT);
    end

    // Phase counters: reset-pulse length, WAIT timeout and lock stability filter.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            pls_cnt <= '0;
            timer   <= '0;
            filt    <= '0;
        end else begin
            pls_cnt <= (state == S_PLLRST && state_next == S_PLLRST) ? pls_cnt + PLS_W'(1) : '0;
            timer   <= (state == S_WAIT && state_next == S_WAIT) ? timer + TMR_W'(1) : '0;
            filt    <= (state == S_WAIT && state_next == S_WAIT && lock_s) ? filt + FILT_W'(1) : '0;
        end
    end

    // Channel decode: effective divisor (first RUN cycle reads div directly) and strobe match.
    always_comb begin
        first_run = locked_q & first_q;
        wrap      = '0;
        ce_w      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            div_n[i] = bus.div[i*DIV_W +: DIV_W];
            if (div_n[i] == '0) div_n[i] = DIV_W'(1);
            d_eff[i] = first_run ? div_n[i] : d_q[i];
            wrap[i]  = (cnt[i] == d_eff[i] - DIV_W'(1));
            ce_w[i]  = locked_q & wrap[i];
        end
    end

    // Channel counters: held at 0 outside RUN, wrap at d-1 and re-latch div at each boundary.
    always_ff @(posedge clkin or posedge reset) begin
        if (reset) begin
            first_q <= 1'b1;
            for (int i = 0; i < NUM_CH; i++) begin
                // NOTE: the divisor registers are plain flops, so they are reset like any other state to keep X off ce.
                cnt[i] <= '0;
                d_q[i] <= '0;
            end
        end else begin
            first_q <= ~locked_q;
            for (int i = 0; i < NUM_CH; i++) begin
                if (locked_q && state_next == S_RUN) begin
                    cnt[i] <= wrap[i] ? '0 : cnt[i] + DIV_W'(1);
                end else begin
                    cnt[i] <= '0;
                end
                if (locked_q && (first_run || wrap[i])) d_q[i] <= div_n[i];
            end
        end
    end

    assign bus.pll_reset = pll_reset_q;
    assign bus.locked    = locked_q;
    assign bus.rst_out   = ~locked_q;
    assign bus.ce        = ce_w;
    assign bus.retry_cnt = retry_q;
    assign bus.fault     = fault_q;

endmodule

// File: tb/tb_pll_clk_supervisor.sv
// Bench for pll_clk_supervisor: directed scenarios plus randomized lock and
// divisor activity, every cycle compared with a behavioural model that tracks
// phase ages, lock streaks and per-channel next-pulse times.
module tb_pll_clk_supervisor;

    localparam int NUM_CH    = 3;
    localparam int DIV_W     = 16;
    localparam int FILT      = 8;
    localparam int TIMEOUT   = 64;
    localparam int RST_PULSE = 4;
    localparam int MAX_RETRY = 2;

    localparam int PH_RST   = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_RUN   = 2;
    localparam int PH_FAULT = 3;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pll_clk_supervisor_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W)) bus ();

    pll_clk_supervisor #(
        .NUM_CH(NUM_CH), .DIV_W(DIV_W), .FILT_CYC(FILT), .TIMEOUT_CYC(TIMEOUT),
        .RST_PULSE_CYC(RST_PULSE), .MAX_RETRY(MAX_RETRY)
    ) dut (
        .clkin(clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Behavioural model state
    int m_phase;
    int m_age;
    int m_streak;
    int m_retry;
    int m_run;
    int m_next [NUM_CH];
    bit samp [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int eff_div(input int ch);
        int v;
        v = int'(bus.div[ch*DIV_W +: DIV_W]);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic bit exp_ce(input int ch);
        if (m_phase != PH_RUN) return 1'b0;
        if (m_next[ch] < 0) return (eff_div(ch) == 1);
        return (m_run == m_next[ch]);
    endfunction

    task automatic model_reset();
        m_phase  = PH_RST;
        m_age    = 0;
        m_streak = 0;
        m_retry  = 0;
        m_run    = 0;
        for (int i = 0; i < NUM_CH; i++) m_next[i] = -1;
        samp.delete();
        samp.push_back(1'b0);
        samp.push_back(1'b0);
    endtask

    // Advance the model across the clock edge that just happened.
    task automatic model_step();
        bit ls;
        ls = samp[1];
        samp.push_front(bus.pll_lock);
        void'(samp.pop_back());
        case (m_phase)
            PH_RST: begin
                m_age++;
                if (m_age == RST_PULSE) begin
                    m_phase  = PH_WAIT;
                    m_age    = 0;
                    m_streak = 0;
                end
            end
            PH_WAIT: begin
                m_age++;
                if (m_streak == FILT) begin
                    m_phase = PH_RUN;
                    m_retry = 0;
                    m_run   = 0;
                    for (int i = 0; i < NUM_CH; i++) m_next[i] = -1;
                end else if (m_age == TIMEOUT) begin
                    m_retry = (m_retry < 255) ? m_retry + 1 : 255;
                    m_phase = (MAX_RETRY != 0 && m_retry == MAX_RETRY) ? PH_FAULT : PH_RST;
                    m_age   = 0;
                end else begin
                    m_streak = ls ? m_streak + 1 : 0;
                end
            end
            PH_RUN: begin
                if (!ls) begin
                    m_phase = PH_RST;
                    m_age   = 0;
                end else begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (m_next[i] < 0) m_next[i] = eff_div(i) - 1;
                        if (m_run == m_next[i]) m_next[i] = m_run + eff_div(i);
                    end
                    m_run++;
                end
            end
            default: ;
        endcase
    endtask

    task automatic compare_model();
        logic [NUM_CH-1:0] e;
        for (int i = 0; i < NUM_CH; i++) e[i] = exp_ce(i);
        check("locked",    32'(bus.locked),    32'(m_phase == PH_RUN));
        check("rst_out",   32'(bus.rst_out),   32'(m_phase != PH_RUN));
        check("pll_reset", 32'(bus.pll_reset), 32'(m_phase == PH_RST || m_phase == PH_FAULT));
        check("fault",     32'(bus.fault),     32'(m_phase == PH_FAULT));
        check("retry_cnt", 32'(bus.retry_cnt), 32'(m_retry));
        check("ce",        32'(bus.ce),        32'(e));
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        model_step();
        compare_model();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_reset"}, 32'(bus.pll_reset), 32'd1);
        check({tag, "_locked"},    32'(bus.locked),    32'd0);
        check({tag, "_rst_out"},   32'(bus.rst_out),   32'd1);
        check({tag, "_ce"},        32'(bus.ce),        32'd0);
        check({tag, "_retry"},     32'(bus.retry_cnt), 32'd0);
        check({tag, "_fault"},     32'(bus.fault),     32'd0);
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        bus.pll_lock = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("in_reset");
        reset = 1'b0;
        model_reset();
        compare_model();
    endtask

    task automatic pulse_len(output int n);
        n = 0;
        while (bus.pll_reset === 1'b1 && n < 50) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_locked(input logic val, input int budget, output int n);
        n = 0;
        while (bus.locked !== val && n < budget) begin
            tick();
            n++;
        end
        check("wait_locked_bound", 32'(bus.locked), 32'(val));
    endtask

    initial begin
        int n;
        int n2;
        int t;
        int t_rise;
        int t_fault;
        int r_rise;
        int r_fault;
        bit prev_rst;
        bit prev_fault;
        bit saved;
        int p;

        checks       = 0;
        errors       = 0;
        reset        = 1'b1;
        bus.pll_lock = 1'b0;
        bus.div      = {16'd1, 16'd2, 16'd5};
        #1;
        check_reset_values("por");

        // Normal lock: 4-cycle PLL reset, lock 11 cycles after WAIT entry
        do_reset();
        pulse_len(n);
        check("pll_reset_pulse_len", 32'(n), 32'(RST_PULSE));
        bus.pll_lock = 1'b1;
        wait_locked(1'b1, 40, n);
        check("lock_latency", 32'(n), 32'(FILT + 3));
        for (int r = 0; r < 16; r++) begin
            check("ce0_div5", 32'(bus.ce[0]), 32'(r % 5 == 4));
            check("ce1_div2", 32'(bus.ce[1]), 32'(r % 2 == 1));
            check("ce2_div1", 32'(bus.ce[2]), 32'd1);
            tick();
        end

        // Sub-cycle glitch never reaches the synchroniser
        bus.pll_lock = 1'b0;
        #2;
        bus.pll_lock = 1'b1;
        repeat (4) tick();
        check("glitch_ignored", 32'(bus.locked), 32'd1);

        // Lock loss in RUN: 3 edges later everything drops, retry unchanged
        bus.pll_lock = 1'b0;
        wait_locked(1'b0, 10, n);
        check("loss_latency", 32'(n), 32'd3);
        check("loss_pll_reset", 32'(bus.pll_reset), 32'd1);
        check("loss_rst_out",   32'(bus.rst_out),   32'd1);
        check("loss_ce",        32'(bus.ce),        32'd0);
        check("loss_retry",     32'(bus.retry_cnt), 32'd0);
        bus.pll_lock = 1'b1;
        wait_locked(1'b1, 60, n);

        // Aligned restart and mid-period divisor changes (5 -> 3 at cycle 6, -> 0 at 16)
        for (int r = 0; r < 23; r++) begin
            check("re_ce0", 32'(bus.ce[0]),
                  32'(r == 4 || r == 9 || r == 12 || r == 15 || r == 18 || r >= 19));
            check("re_ce1", 32'(bus.ce[1]), 32'(r % 2 == 1));
            check("re_ce2", 32'(bus.ce[2]), 32'd1);
            if (r == 6)  bus.div[0 +: DIV_W] = 16'd3;
            if (r == 16) bus.div[0 +: DIV_W] = 16'd0;
            tick();
        end

        // Async reset between edges
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("async");
        do_reset();
        bus.pll_lock = 1'b1;
        pulse_len(n);
        check("post_async_pulse_len", 32'(n), 32'(RST_PULSE));
        wait_locked(1'b1, 40, n);
        check("post_async_lock", 32'(n), 32'(FILT + 1));

        // Lock bounce in WAIT: filter restarts after the low sample
        bus.div = {16'd1, 16'd2, 16'd5};
        do_reset();
        pulse_len(n);
        bus.pll_lock = 1'b1;
        repeat (7) tick();
        bus.pll_lock = 1'b0;
        tick();
        bus.pll_lock = 1'b1;
        wait_locked(1'b1, 40, n2);
        check("bounce_latency", 32'(8 + n2), 32'(FILT + 3 + 8));

        // Timeout retries ending in FAULT
        do_reset();
        t = 0; t_rise = -1; t_fault = -1; r_rise = -1; r_fault = -1;
        prev_rst = 1'b1; prev_fault = 1'b0;
        while (t < 200 && t_fault < 0) begin
            tick();
            t++;
            if (!prev_rst && bus.pll_reset === 1'b1 && t_rise < 0) begin
                t_rise = t;
                r_rise = int'(bus.retry_cnt);
            end
            if (!prev_fault && bus.fault === 1'b1) begin
                t_fault = t;
                r_fault = int'(bus.retry_cnt);
            end
            prev_rst   = bus.pll_reset;
            prev_fault = bus.fault;
        end
        check("retry_pulse_period", 32'(t_rise),  32'(RST_PULSE + TIMEOUT));
        check("retry_cnt_first",    32'(r_rise),  32'd1);
        check("fault_time",         32'(t_fault), 32'(2 * (RST_PULSE + TIMEOUT)));
        check("retry_cnt_fault",    32'(r_fault), 32'd2);
        repeat (30) tick();
        check("fault_hold_pll_reset", 32'(bus.pll_reset), 32'd1);

        // Randomized lock noise and divisor churn
        for (int it = 0; it < 6; it++) begin
            do_reset();
            for (int i = 0; i < NUM_CH; i++) bus.div[i*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 7));
            p = (it % 3 == 0) ? 100 : (it % 3 == 1) ? 98 : 85;
            for (int c = 0; c < 160; c++) begin
                bus.pll_lock = ($urandom_range(0, 99) < p);
                if ($urandom_range(0, 19) == 0) begin
                    bus.div[$urandom_range(0, NUM_CH - 1)*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 7));
                end
                if ($urandom_range(0, 29) == 0) begin
                    saved        = bus.pll_lock;
                    bus.pll_lock = ~saved;
                    #2;
                    bus.pll_lock = saved;
                end
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
